elevator_call_scheduler: RTL

- Collects cabin (interior) and hall (exterior) floor calls into a pending-request bitmap and picks the next target floor with a SCAN policy (keep direction while calls remain ahead, else reverse).
- Sits directly upstream of the elevator controller: it feeds the target floor and consumes the controller's current-floor and arrival reports.
- A door-dwell counter holds off re-targeting after each arrival.

---
 rtl/elevator_pkg.sv | 26 ++
 rtl/scan_select.sv | 74 +++++++
 rtl/elevator_call_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator subsystem: scheduler FSM encoding,
// default geometry and the engine/door codes used by the elevator controller.
package elevator_pkg;

    localparam int NUM_FLOORS_DEF = 8;
    localparam int FLOOR_W_DEF    = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MOVE   = 2'd1;
    localparam logic [1:0] ST_DWELL  = 2'd2;
    localparam logic [1:0] ST_SELECT = 2'd3;

    typedef enum logic [1:0] {
        ENG_STOP = 2'd0,
        ENG_UP   = 2'd1,
        ENG_DOWN = 2'd2
    } engine_cmd_e;

    typedef enum logic [1:0] {
        DOOR_CLOSED  = 2'd0,
        DOOR_OPENING = 2'd1,
        DOOR_OPEN    = 2'd2,
        DOOR_CLOSING = 2'd3
    } door_state_e;

endpackage

// File: rtl/scan_select.sv
// Combinational SCAN pick: nearest pending floor ahead in the current
// direction, otherwise the nearest one behind with the direction reversed.
module scan_select
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  dir_up,
    output logic                  found,
    output logic [FLOOR_W-1:0]    next_floor,
    output logic                  next_dir_up
);

    logic               up_found;
    logic               dn_found;
    logic [FLOOR_W-1:0] up_floor;
    logic [FLOOR_W-1:0] dn_floor;

    // The last hit of each loop is the floor closest to cur_floor.
    always_comb begin
        up_found = 1'b0;
        up_floor = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(cur_floor))) begin
                up_found = 1'b1;
                up_floor = FLOOR_W'(i);
            end
        end
        dn_found = 1'b0;
        dn_floor = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(cur_floor))) begin
                dn_found = 1'b1;
                dn_floor = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        found       = 1'b0;
        next_floor  = cur_floor;
        next_dir_up = dir_up;
        if (int'(cur_floor) >= NUM_FLOORS - 1) begin
            next_dir_up = 1'b0;
        end else if (cur_floor == '0) begin
            next_dir_up = 1'b1;
        end
        if (dir_up) begin
            if (up_found) begin
                found       = 1'b1;
                next_floor  = up_floor;
                next_dir_up = 1'b1;
            end else if (dn_found) begin
                found       = 1'b1;
                next_floor  = dn_floor;
                next_dir_up = 1'b0;
            end
        end else begin
            if (dn_found) begin
                found       = 1'b1;
                next_floor  = dn_floor;
                next_dir_up = 1'b0;
            end else if (up_found) begin
                found       = 1'b1;
                next_floor  = up_floor;
                next_dir_up = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Collects cabin and hall calls and issues SCAN-ordered target floors to the
// elevator controller, holding off re-targeting for a door dwell after arrival.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
    parameter int FLOOR_W      = FLOOR_W_DEF,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  int_call_valid,
    input  logic [FLOOR_W-1:0]    int_call_floor,
    input  logic                  ext_call_valid,
    input  logic [FLOOR_W-1:0]    ext_call_floor,
    input  logic                  clear_all,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  arrived,
    output logic                  target_valid,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);

    localparam int DW_W = $clog2(DWELL_CYCLES + 1);

    logic [1:0]            state_q,   state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    target_q,  target_d;
    logic                  tvalid_q,  tvalid_d;
    logic                  dir_q,     dir_d;
    logic [DW_W-1:0]       dwell_q,   dwell_d;

    logic [NUM_FLOORS-1:0] cur_bit;
    logic [NUM_FLOORS-1:0] new_calls;
    logic [NUM_FLOORS-1:0] scan_pending;
    logic                  sc_found;
    logic [FLOOR_W-1:0]    sc_floor;
    logic                  sc_dir;
    logic                  retarget;

    // Out-of-range floor codes decode to an empty mask.
    function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (int'(f) == i);
        end
        return m;
    endfunction

    always_comb begin
        cur_bit   = floor_bit(cur_floor);
        new_calls = '0;
        if (int_call_valid) new_calls = new_calls | floor_bit(int_call_floor);
        if (ext_call_valid) new_calls = new_calls | floor_bit(ext_call_floor);
        if (state_q == ST_DWELL) new_calls = new_calls & ~cur_bit;
    end

    // While moving, same-cycle calls are seen so a retarget lands on the next edge.
    assign scan_pending = (state_q == ST_MOVE) ? (pending_q | new_calls) : pending_q;

    scan_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan (
        .pending     (scan_pending),
        .cur_floor   (cur_floor),
        .dir_up      (dir_q),
        .found       (sc_found),
        .next_floor  (sc_floor),
        .next_dir_up (sc_dir)
    );

    assign retarget = sc_found && (sc_dir == dir_q) &&
                      (dir_q ? (sc_floor < target_q) : (sc_floor > target_q));

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | new_calls;
        target_d  = target_q;
        tvalid_d  = tvalid_q;
        dir_d     = dir_q;
        dwell_d   = dwell_q;
        if (clear_all) begin
            pending_d = '0;
            tvalid_d  = 1'b0;
            dwell_d   = '0;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_SELECT: begin
                    if (pending_q != '0) begin
                        dir_d = sc_dir;
                        if (sc_found) begin
                            target_d = sc_floor;
                            tvalid_d = 1'b1;
                            state_d  = ST_MOVE;
                        end else begin
                            // Only the current floor is pending: just reopen the doors.
                            pending_d = pending_d & ~cur_bit;
                            dwell_d   = DW_W'(DWELL_CYCLES);
                            state_d   = ST_DWELL;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MOVE: begin
                    if (arrived && (cur_floor == target_q)) begin
                        pending_d = pending_d & ~cur_bit;
                        tvalid_d  = 1'b0;
                        dwell_d   = DW_W'(DWELL_CYCLES);
                        state_d   = ST_DWELL;
                    end else begin
                        if (arrived) pending_d = pending_d & ~cur_bit;
                        if (retarget) target_d = sc_floor;
                    end
                end
                ST_DWELL: begin
                    if (dwell_q <= DW_W'(1)) begin
                        dwell_d = '0;
                        state_d = ST_SELECT;
                    end else begin
                        dwell_d = dwell_q - DW_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            target_q  <= '0;
            tvalid_q  <= 1'b0;
            dir_q     <= 1'b1;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            tvalid_q  <= tvalid_d;
            dir_q     <= dir_d;
            dwell_q   <= dwell_d;
        end
    end

    assign target_valid = tvalid_q;
    assign target_floor = target_q;
    assign dir_up       = dir_q;
    assign pending      = pending_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
